// File: rtl/ro_puf_meas.sv
// Ring-oscillator PUF measurement engine: enables a pair of ROs, lets them settle,
// counts synchronised rising edges of both over a window and compares the totals.
module ro_puf_meas #(
    parameter int N_CH   = 8,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(N_CH):0]     ch_a,
    input  logic [$clog2(N_CH):0]     ch_b,
    input  logic [WIN_W-1:0]          win_len,
    input  logic [N_CH-1:0]           ro_div,
    output logic [N_CH-1:0]           ro_en,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          count_a,
    output logic [CNT_W-1:0]          count_b,
    output logic                      resp,
    output logic                      tie,
    output logic                      sat_a,
    output logic                      sat_b,
    output logic                      err
);
    localparam int CH_W = $clog2(N_CH) + 1;
    localparam logic [WIN_W-1:0] SETTLE_M1 = WIN_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIN_W-1:0]  timer_reg, timer_next;
    logic [WIN_W-1:0]  win_reg;
    logic [CH_W-1:0]   ch_a_reg, ch_b_reg;
    logic [N_CH-1:0]   sync1_reg, sync2_reg, sync3_reg;
    logic [CNT_W-1:0]  count_a_reg, count_b_reg;
    logic              sat_a_reg, sat_b_reg, err_reg, valid_reg;
    logic [N_CH-1:0]   sel_a, sel_b, edge_vec;
    logic              accept, illegal, hit_a, hit_b, enabled;

    // One-hot channel selects avoid variable-width indexing into the RO vectors.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_sel
        assign sel_a[gi] = (ch_a_reg == CH_W'(gi));
        assign sel_b[gi] = (ch_b_reg == CH_W'(gi));
    end

    assign edge_vec = sync2_reg & ~sync3_reg;
    assign enabled  = (state_reg == ARM) || (state_reg == MEASURE);
    assign hit_a    = (state_reg == MEASURE) && |(edge_vec & sel_a);
    assign hit_b    = (state_reg == MEASURE) && |(edge_vec & sel_b);
    assign illegal  = (ch_a >= CH_W'(N_CH)) || (ch_b >= CH_W'(N_CH));

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = illegal ? DONE : ARM;
                    timer_next = SETTLE_M1;
                end
            end
            ARM: begin
                if (timer_reg == '0) begin
                    if (win_reg == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = MEASURE;
                        timer_next = win_reg - 1'b1;
                    end
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            MEASURE: begin
                if (timer_reg == '0) begin
                    state_next = DONE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            win_reg     <= '0;
            ch_a_reg    <= '0;
            ch_b_reg    <= '0;
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            sync3_reg   <= '0;
            count_a_reg <= '0;
            count_b_reg <= '0;
            sat_a_reg   <= 1'b0;
            sat_b_reg   <= 1'b0;
            err_reg     <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            sync1_reg <= ro_div;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            if (accept) begin
                ch_a_reg    <= ch_a;
                ch_b_reg    <= ch_b;
                win_reg     <= win_len;
                count_a_reg <= '0;
                count_b_reg <= '0;
                sat_a_reg   <= 1'b0;
                sat_b_reg   <= 1'b0;
                err_reg     <= illegal;
                valid_reg   <= 1'b0;
            end else begin
                if (hit_a) begin
                    if (count_a_reg == CNT_MAX) sat_a_reg <= 1'b1;
                    else count_a_reg <= count_a_reg + 1'b1;
                end
                if (hit_b) begin
                    if (count_b_reg == CNT_MAX) sat_b_reg <= 1'b1;
                    else count_b_reg <= count_b_reg + 1'b1;
                end
                // Comparison results only become meaningful once a legal window has closed.
                if (enabled && state_next == DONE) valid_reg <= 1'b1;
            end
        end
    end

    assign ro_en   = enabled ? (sel_a | sel_b) : '0;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign count_a = count_a_reg;
    assign count_b = count_b_reg;
    assign resp    = valid_reg && (count_a_reg > count_b_reg);
    assign tie     = valid_reg && (count_a_reg == count_b_reg);
    assign sat_a   = sat_a_reg;
    assign sat_b   = sat_b_reg;
    assign err     = err_reg;
endmodule

// File: tb/tb_ro_puf_meas.sv
// Directed bench for ro_puf_meas: free-running divided ROs with fixed per-channel periods.
module tb_ro_puf_meas;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic [3:0]  ch_a = '0, ch_b = '0, ch_a2 = '0, ch_b2 = '0;
    logic [15:0] win_len = '0, win_len2 = '0;
    logic [7:0]  ro_div = '0;
    logic [7:0]  ro_en, ro_en2;
    logic        busy, done, resp, tie, sat_a, sat_b, err;
    logic        busy2, done2, resp2, tie2, sat_a2, sat_b2, err2;
    logic [15:0] count_a, count_b;
    logic [3:0]  count_a2, count_b2;
    int          tests = 0, fails = 0;
    int          cyc = 0;

    ro_puf_meas #(.N_CH(8), .CNT_W(16), .WIN_W(16), .SETTLE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_a(ch_a), .ch_b(ch_b), .win_len(win_len),
        .ro_div(ro_div), .ro_en(ro_en), .busy(busy), .done(done), .count_a(count_a),
        .count_b(count_b), .resp(resp), .tie(tie), .sat_a(sat_a), .sat_b(sat_b), .err(err));

    ro_puf_meas #(.N_CH(8), .CNT_W(4), .WIN_W(16), .SETTLE(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .ch_a(ch_a2), .ch_b(ch_b2), .win_len(win_len2),
        .ro_div(ro_div), .ro_en(ro_en2), .busy(busy2), .done(done2), .count_a(count_a2),
        .count_b(count_b2), .resp(resp2), .tie(tie2), .sat_a(sat_a2), .sat_b(sat_b2), .err(err2));

    always #5 clk = ~clk;

    function automatic int per_of(input int k);
        case (k)
            0: return 4;
            1: return 6;
            2: return 4;
            3: return 6;
            4: return 10;
            5: return 8;
            6: return 12;
            default: return 14;
        endcase
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 8; k++) ro_div[k] = ((cyc % per_of(k)) < (per_of(k) / 2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one measurement on the main instance; returns latency to done and the
    // OR/AND of ro_en over the busy cycles before DONE. Inputs are scrambled mid-run.
    task automatic run_meas(input logic [3:0] a, input logic [3:0] b, input logic [15:0] wl,
                            output int lat, output logic [7:0] en_or, output logic [7:0] en_and);
        ch_a = a; ch_b = b; win_len = wl; start = 1'b1;
        lat = 0; en_or = '0; en_and = 8'hFF;
        while (lat < 400) begin
            tick();
            lat++;
            if (lat == 1) start = 1'b0;
            if (lat == 3) begin ch_a = 4'd7; ch_b = 4'd6; win_len = 16'd3; start = 1'b1; end
            if (lat == 4) start = 1'b0;
            if (done) break;
            en_or  = en_or | ro_en;
            en_and = en_and & ro_en;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || ro_en !== 8'h00) begin fails++;
            $display("FAIL reset_ctrl: busy=%0b done=%0b ro_en=%h expected 0 0 00", busy, done, ro_en); end
        tests++; if (count_a !== 16'd0 || count_b !== 16'd0 || {resp, tie, sat_a, sat_b, err} !== 5'b0) begin fails++;
            $display("FAIL reset_results: ca=%0d cb=%0d flags=%b expected 0 0 00000", count_a, count_b, {resp, tie, sat_a, sat_b, err}); end
        tests++; if (busy2 !== 1'b0 || count_a2 !== 4'd0 || sat_a2 !== 1'b0) begin fails++;
            $display("FAIL reset_sat_inst: busy=%0b ca=%0d sat=%0b expected 0 0 0", busy2, count_a2, sat_a2); end
    endtask

    task automatic test_basic();
        int lat; logic [7:0] eo, ea;
        run_meas(4'd2, 4'd5, 16'd64, lat, eo, ea);
        tests++; if (lat !== 69) begin fails++; $display("FAIL basic_latency: got %0d expected 69", lat); end
        tests++; if (eo !== 8'b0010_0100 || ea !== 8'b0010_0100) begin fails++;
            $display("FAIL basic_ro_en: or=%b and=%b expected 00100100", eo, ea); end
        tests++; if (count_a !== 16'd16 || count_b !== 16'd8) begin fails++;
            $display("FAIL basic_counts: ca=%0d cb=%0d expected 16 8", count_a, count_b); end
        tests++; if (resp !== 1'b1 || tie !== 1'b0 || err !== 1'b0 || busy !== 1'b1 || ro_en !== 8'h00) begin fails++;
            $display("FAIL basic_done_flags: resp=%0b tie=%0b err=%0b busy=%0b ro_en=%h expected 1 0 0 1 00", resp, tie, err, busy, ro_en); end
        tick(); tick();
        tests++; if (busy !== 1'b0 || count_a !== 16'd16 || resp !== 1'b1) begin fails++;
            $display("FAIL basic_hold: busy=%0b ca=%0d resp=%0b expected 0 16 1", busy, count_a, resp); end
    endtask

    task automatic test_same_channel();
        int lat; logic [7:0] eo, ea;
        run_meas(4'd3, 4'd3, 16'd60, lat, eo, ea);
        tests++; if (lat !== 65 || eo !== 8'b0000_1000) begin fails++;
            $display("FAIL same_lat_en: lat=%0d ro_en=%b expected 65 00001000", lat, eo); end
        tests++; if (count_a !== 16'd10 || count_b !== 16'd10 || tie !== 1'b1 || resp !== 1'b0) begin fails++;
            $display("FAIL same_result: ca=%0d cb=%0d tie=%0b resp=%0b expected 10 10 1 0", count_a, count_b, tie, resp); end
    endtask

    task automatic test_saturation();
        int lat = 0;
        ch_a2 = 4'd2; ch_b2 = 4'd4; win_len2 = 16'd100; start2 = 1'b1;
        while (lat < 400) begin
            tick();
            lat++;
            if (lat == 1) start2 = 1'b0;
            if (done2) break;
        end
        tests++; if (lat !== 105) begin fails++; $display("FAIL sat_latency: got %0d expected 105", lat); end
        tests++; if (count_a2 !== 4'd15 || sat_a2 !== 1'b1 || count_b2 !== 4'd10 || sat_b2 !== 1'b0 || resp2 !== 1'b1) begin fails++;
            $display("FAIL sat_result: ca=%0d sa=%0b cb=%0d sb=%0b resp=%0b expected 15 1 10 0 1", count_a2, sat_a2, count_b2, sat_b2, resp2); end
        tick(); tick(); tick();
        tests++; if (busy2 !== 1'b0 || sat_a2 !== 1'b1 || count_a2 !== 4'd15) begin fails++;
            $display("FAIL sat_sticky: busy=%0b sa=%0b ca=%0d expected 0 1 15", busy2, sat_a2, count_a2); end
    endtask

    task automatic test_err_and_zero();
        int lat; logic [7:0] eo, ea;
        run_meas(4'd9, 4'd1, 16'd20, lat, eo, ea);
        tests++; if (lat !== 1 || err !== 1'b1 || eo !== 8'h00 || ro_en !== 8'h00) begin fails++;
            $display("FAIL err_done: lat=%0d err=%0b ro_en_seen=%h ro_en=%h expected 1 1 00 00", lat, err, eo, ro_en); end
        tests++; if (count_a !== 16'd0 || count_b !== 16'd0 || tie !== 1'b0 || resp !== 1'b0) begin fails++;
            $display("FAIL err_counts: ca=%0d cb=%0d tie=%0b resp=%0b expected 0 0 0 0", count_a, count_b, tie, resp); end
        tick();
        run_meas(4'd2, 4'd5, 16'd0, lat, eo, ea);
        tests++; if (lat !== 5 || eo !== 8'b0010_0100) begin fails++;
            $display("FAIL zero_latency: lat=%0d ro_en=%b expected 5 00100100", lat, eo); end
        tests++; if (count_a !== 16'd0 || count_b !== 16'd0 || tie !== 1'b1 || resp !== 1'b0 || err !== 1'b0) begin fails++;
            $display("FAIL zero_result: ca=%0d cb=%0d tie=%0b resp=%0b err=%0b expected 0 0 1 0 0", count_a, count_b, tie, resp, err); end
        tick();
    endtask

    task automatic test_mid_reset();
        int lat; logic [7:0] eo, ea;
        ch_a = 4'd0; ch_b = 4'd1; win_len = 16'd24; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        tests++; if (busy !== 1'b1 || count_a === 16'd0) begin fails++;
            $display("FAIL midrst_pre: busy=%0b ca=%0d expected 1 nonzero", busy, count_a); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if ({busy, done, resp, tie, sat_a, sat_b, err} !== 7'b0 || ro_en !== 8'h00 || count_a !== 16'd0 || count_b !== 16'd0) begin fails++;
            $display("FAIL midrst_clear: flags=%b ro_en=%h ca=%0d cb=%0d expected 0000000 00 0 0", {busy, done, resp, tie, sat_a, sat_b, err}, ro_en, count_a, count_b); end
        run_meas(4'd0, 4'd1, 16'd24, lat, eo, ea);
        tests++; if (lat !== 29 || count_a !== 16'd6 || count_b !== 16'd4 || resp !== 1'b1) begin fails++;
            $display("FAIL midrst_rerun: lat=%0d ca=%0d cb=%0d resp=%0b expected 29 6 4 1", lat, count_a, count_b, resp); end
        tick();
    endtask

    task automatic test_back_to_back();
        int dc [3];
        int d = 0, lat = 0, busy_seen = 0;
        ch_a = 4'd2; ch_b = 4'd5; win_len = 16'd24; start = 1'b1;
        while (lat < 300 && d < 3) begin
            tick();
            lat++;
            if (done) begin
                dc[d] = lat;
                d++;
                if (d == 3) start = 1'b0;
            end
        end
        tests++; if (d !== 3) begin fails++; $display("FAIL b2b_count: got %0d done pulses expected 3", d); end
        else begin
            tests++; if (dc[0] !== 29 || dc[1] - dc[0] !== 30 || dc[2] - dc[1] !== 30) begin fails++;
                $display("FAIL b2b_spacing: first=%0d gaps=%0d,%0d expected 29 30,30", dc[0], dc[1] - dc[0], dc[2] - dc[1]); end
        end
        tests++; if (count_a !== 16'd6 || count_b !== 16'd3 || resp !== 1'b1) begin fails++;
            $display("FAIL b2b_counts: ca=%0d cb=%0d resp=%0b expected 6 3 1", count_a, count_b, resp); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        tests++; if (busy_seen !== 0) begin fails++;
            $display("FAIL b2b_no_queue: busy for %0d cycles after release expected 0", busy_seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_channel();
        test_saturation();
        test_err_and_zero();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
